// File: rtl/load_use_hazard_unit_pkg.sv
// Shared RISC-V definitions for the decode-side hazard logic.
// Base-ISA major opcodes, used by both the hazard detector and the forwarding unit.
package load_use_hazard_unit_pkg;

  localparam logic [6:0] R_TYPE      = 7'b0110011;
  localparam logic [6:0] I_TYPE      = 7'b0010011;
  localparam logic [6:0] I_TYPE_LOAD = 7'b0000011;
  localparam logic [6:0] I_JALR      = 7'b1100111;
  localparam logic [6:0] S_TYPE      = 7'b0100011;
  localparam logic [6:0] B_TYPE      = 7'b1100011;
  localparam logic [6:0] LUI         = 7'b0110111;
  localparam logic [6:0] AUIPC       = 7'b0010111;
  localparam logic [6:0] JAL         = 7'b1101111;

  localparam int INSTR_W = 32;

endpackage

// File: rtl/load_use_hazard_unit_if.sv
// Decode-side bus between the pipeline control and the load-use hazard unit.
// master drives the decode instruction and pipe status; slave returns the stall controls.
interface load_use_hazard_unit_if #(
  parameter int REG_AW  = 5,
  parameter int COUNT_W = 16
);
  logic [31:0]        instruction;
  logic               instr_valid;
  logic               flush;
  logic               dmem_stall;
  logic               stall_if;
  logic               stall_dec;
  logic               stall_ex;
  logic               bubble_ex;
  logic [REG_AW-1:0]  hazard_reg;
  logic [COUNT_W-1:0] stall_cycles;

  modport master (
    output instruction, instr_valid, flush, dmem_stall,
    input  stall_if, stall_dec, stall_ex, bubble_ex, hazard_reg, stall_cycles
  );

  modport slave (
    input  instruction, instr_valid, flush, dmem_stall,
    output stall_if, stall_dec, stall_ex, bubble_ex, hazard_reg, stall_cycles
  );
endinterface

// File: rtl/load_use_hazard_unit_hazard_src_decode.sv
// Opcode to source-register usage decode; purely combinational, shared with the forwarding unit.
module hazard_src_decode
  import load_use_hazard_unit_pkg::*;
(
  input  logic [6:0] opcode,
  output logic       uses_rs1,
  output logic       uses_rs2,
  output logic       is_load
);

  // NOTE: every output gets a default before the case so no path leaves one unassigned (no latch).
  always_comb begin
    uses_rs1 = 1'b0;
    uses_rs2 = 1'b0;
    is_load  = 1'b0;
    unique case (opcode)
      R_TYPE, S_TYPE, B_TYPE: begin
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
      end
      I_TYPE, I_JALR: uses_rs1 = 1'b1;
      I_TYPE_LOAD: begin
        uses_rs1 = 1'b1;
        is_load  = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/load_use_hazard_unit.sv
// Load-use hazard detector beside decode: tracks in-flight loads, stalls IF/DEC and bubbles EX
// until a dependent instruction can take the forwarded result; counts stall cycles.
module load_use_hazard_unit
  import load_use_hazard_unit_pkg::*;
#(
  parameter int LOAD_LAT = 1,
  parameter int REG_AW   = 5,
  parameter int COUNT_W  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  load_use_hazard_unit_if.slave bus
);

  logic [6:0]        opcode;
  logic [REG_AW-1:0] rs1, rs2, rd;
  logic              uses_rs1, uses_rs2, is_load;

  assign opcode = bus.instruction[6:0];
  assign rd     = REG_AW'(bus.instruction[11:7]);
  assign rs1    = REG_AW'(bus.instruction[19:15]);
  assign rs2    = REG_AW'(bus.instruction[24:20]);

  hazard_src_decode u_src_decode (
    .opcode   (opcode),
    .uses_rs1 (uses_rs1),
    .uses_rs2 (uses_rs2),
    .is_load  (is_load)
  );

  logic [LOAD_LAT-1:0]             ent_valid;
  logic [LOAD_LAT-1:0][REG_AW-1:0] ent_rd;
  logic                            live, lu_hit, capture;
  logic                            rs1_hit, rs2_hit, rs1_dep, rs2_dep;

  // entry[0] is one stage past decode; each older entry is one more cycle down the pipe.
  for (genvar i = 0; i < LOAD_LAT; i++) begin : g_trk
    logic              v_q;
    logic [REG_AW-1:0] rd_q;
    if (i == 0) begin : g_head
      // NOTE: the tracker is only LOAD_LAT flops, so it is reset; an async clear is what drops a stall at once.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          v_q  <= 1'b0;
          rd_q <= '0;
        end else if (!bus.dmem_stall) begin
          v_q  <= capture;
          rd_q <= rd;
        end
      end
    end else begin : g_tail
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          v_q  <= 1'b0;
          rd_q <= '0;
        end else if (!bus.dmem_stall) begin
          v_q  <= ent_valid[i-1];
          rd_q <= ent_rd[i-1];
        end
      end
    end
    assign ent_valid[i] = v_q;
    assign ent_rd[i]    = rd_q;
  end

  always_comb begin
    rs1_hit = 1'b0;
    rs2_hit = 1'b0;
    for (int k = 0; k < LOAD_LAT; k++) begin
      if (ent_valid[k] && ent_rd[k] == rs1) rs1_hit = 1'b1;
      if (ent_valid[k] && ent_rd[k] == rs2) rs2_hit = 1'b1;
    end
  end

  assign live    = bus.instr_valid && !bus.flush;
  assign rs1_dep = live && uses_rs1 && (rs1 != '0) && rs1_hit;
  assign rs2_dep = live && uses_rs2 && (rs2 != '0) && rs2_hit;
  assign lu_hit  = rs1_dep || rs2_dep;

  // A stalled load stays in decode, so it is only recorded on the cycle it actually leaves.
  assign capture = live && !lu_hit && is_load && (rd != '0);

  assign bus.stall_if   = lu_hit || bus.dmem_stall;
  assign bus.stall_dec  = lu_hit || bus.dmem_stall;
  assign bus.stall_ex   = bus.dmem_stall;
  assign bus.bubble_ex  = lu_hit && !bus.dmem_stall;
  assign bus.hazard_reg = rs1_dep ? rs1 : (rs2_dep ? rs2 : '0);

  logic [COUNT_W-1:0] stall_cnt;

  // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
    end else if (bus.stall_if && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

  assign bus.stall_cycles = stall_cnt;

endmodule

// File: tb/tb_load_use_hazard_unit.sv
// Directed bench for load_use_hazard_unit: instance A has LOAD_LAT=1 with a 3-bit counter,
// instance B has LOAD_LAT=2 with a 16-bit counter.
module tb_load_use_hazard_unit;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  load_use_hazard_unit_if #(.REG_AW(5), .COUNT_W(3))  bus_a ();
  load_use_hazard_unit_if #(.REG_AW(5), .COUNT_W(16)) bus_b ();

  load_use_hazard_unit #(.LOAD_LAT(1), .REG_AW(5), .COUNT_W(3)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a.slave)
  );

  load_use_hazard_unit #(.LOAD_LAT(2), .REG_AW(5), .COUNT_W(16)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b.slave)
  );

  function automatic logic [31:0] enc_lw(int rd, int rs1);
    return {12'd0, 5'(rs1), 3'b010, 5'(rd), 7'b0000011};
  endfunction
  function automatic logic [31:0] enc_add(int rd, int rs1, int rs2);
    return {7'd0, 5'(rs2), 5'(rs1), 3'b000, 5'(rd), 7'b0110011};
  endfunction
  function automatic logic [31:0] enc_addi(int rd, int rs1);
    return {12'd0, 5'(rs1), 3'b000, 5'(rd), 7'b0010011};
  endfunction
  function automatic logic [31:0] enc_lui(int rd, int imm);
    return {20'(imm), 5'(rd), 7'b0110111};
  endfunction
  function automatic logic [31:0] enc_sw(int rs2, int rs1);
    return {7'd0, 5'(rs2), 5'(rs1), 3'b010, 5'd0, 7'b0100011};
  endfunction
  function automatic logic [31:0] enc_beq(int rs1, int rs2);
    return {7'd0, 5'(rs2), 5'(rs1), 3'b000, 5'd0, 7'b1100011};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // {stall_if, stall_dec, stall_ex, bubble_ex, hazard_reg}
  function automatic logic [31:0] status(bit sel);
    if (sel == 1'b0)
      return {23'd0, bus_a.stall_if, bus_a.stall_dec, bus_a.stall_ex, bus_a.bubble_ex, bus_a.hazard_reg};
    return {23'd0, bus_b.stall_if, bus_b.stall_dec, bus_b.stall_ex, bus_b.bubble_ex, bus_b.hazard_reg};
  endfunction

  // Apply one decode cycle at the falling edge and check the combinational response 1ns later.
  task automatic step(input bit sel, input string tag, input logic [31:0] ins, input logic v,
                      input logic fl, input logic dm, input logic es, input logic ex,
                      input logic eb, input int eh);
    @(negedge clk);
    if (sel == 1'b0) begin
      bus_a.instruction = ins; bus_a.instr_valid = v; bus_a.flush = fl; bus_a.dmem_stall = dm;
    end else begin
      bus_b.instruction = ins; bus_b.instr_valid = v; bus_b.flush = fl; bus_b.dmem_stall = dm;
    end
    #1;
    check(tag, status(sel), {23'd0, es, es, ex, eb, 5'(eh)});
  endtask

  task automatic check_cnt(input bit sel, input string tag, input int exp);
    @(posedge clk);
    #1;
    check(tag, (sel == 1'b0) ? 32'(bus_a.stall_cycles) : 32'(bus_b.stall_cycles), 32'(exp));
  endtask

  initial begin
    bus_a.instruction = '0; bus_a.instr_valid = 1'b0; bus_a.flush = 1'b0; bus_a.dmem_stall = 1'b0;
    bus_b.instruction = '0; bus_b.instr_valid = 1'b0; bus_b.flush = 1'b0; bus_b.dmem_stall = 1'b0;
    rst = 1'b0;
    #12;
    check("rst_a_status", status(1'b0), 32'd0);
    check("rst_b_status", status(1'b1), 32'd0);
    check("rst_a_cnt", 32'(bus_a.stall_cycles), 32'd0);
    check("rst_b_cnt", 32'(bus_b.stall_cycles), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // ---------------- LOAD_LAT = 1 ----------------
    step(0, "a_lw",        enc_lw(5, 1),      1, 0, 0, 0, 0, 0, 0);
    step(0, "a_use",       enc_add(6, 5, 2),  1, 0, 0, 1, 0, 1, 5);
    check_cnt(0, "a_cnt_after_use", 1);
    step(0, "a_use_go",    enc_add(6, 5, 2),  1, 0, 0, 0, 0, 0, 0);
    check_cnt(0, "a_cnt_hold", 1);

    step(0, "a_lw_x0",     enc_lw(0, 1),      1, 0, 0, 0, 0, 0, 0);
    step(0, "a_add_x0",    enc_add(6, 0, 0),  1, 0, 0, 0, 0, 0, 0);

    step(0, "a_lw_lui",    enc_lw(5, 1),      1, 0, 0, 0, 0, 0, 0);
    step(0, "a_lui",       enc_lui(5, 1),     1, 0, 0, 0, 0, 0, 0);

    step(0, "a_lw_bub",    enc_lw(5, 1),      1, 0, 0, 0, 0, 0, 0);
    step(0, "a_invalid",   enc_add(6, 5, 2),  0, 0, 0, 0, 0, 0, 0);
    step(0, "a_dist2",     enc_add(6, 5, 2),  1, 0, 0, 0, 0, 0, 0);

    step(0, "a_lw_sw",     enc_lw(5, 1),      1, 0, 0, 0, 0, 0, 0);
    step(0, "a_sw_rs2",    enc_sw(5, 2),      1, 0, 0, 1, 0, 1, 5);
    step(0, "a_sw_go",     enc_sw(5, 2),      1, 0, 0, 0, 0, 0, 0);
    check_cnt(0, "a_cnt_sw", 2);

    step(0, "a_lw_fl",     enc_lw(5, 1),      1, 0, 0, 0, 0, 0, 0);
    step(0, "a_beq_flush", enc_beq(5, 5),     1, 1, 0, 0, 0, 0, 0);
    step(0, "a_lw7",       enc_lw(7, 1),      1, 0, 0, 0, 0, 0, 0);
    step(0, "a_use7",      enc_add(8, 7, 0),  1, 0, 0, 1, 0, 1, 7);
    step(0, "a_use7_go",   enc_add(8, 7, 0),  1, 0, 0, 0, 0, 0, 0);
    check_cnt(0, "a_cnt_flush", 3);

    step(0, "a_lw_dm",     enc_lw(5, 1),      1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++)
      step(0, $sformatf("a_dmem%0d", i), enc_add(6, 5, 2), 1, 0, 1, 1, 1, 0, 5);
    step(0, "a_dmem_rel",  enc_add(6, 5, 2),  1, 0, 0, 1, 0, 1, 5);
    check_cnt(0, "a_cnt_dmem", 7);
    step(0, "a_dmem_go",   enc_add(6, 5, 2),  1, 0, 0, 0, 0, 0, 0);

    step(0, "a_lw_sat",    enc_lw(9, 1),      1, 0, 0, 0, 0, 0, 0);
    step(0, "a_use_sat",   enc_add(6, 9, 9),  1, 0, 0, 1, 0, 1, 9);
    check_cnt(0, "a_cnt_sat", 7);
    step(0, "a_idle",      32'd0,             0, 0, 0, 0, 0, 0, 0);

    // ---------------- LOAD_LAT = 2 ----------------
    step(1, "b_lw",        enc_lw(5, 1),      1, 0, 0, 0, 0, 0, 0);
    step(1, "b_use_c1",    enc_add(6, 5, 2),  1, 0, 0, 1, 0, 1, 5);
    step(1, "b_use_c2",    enc_add(6, 5, 2),  1, 0, 0, 1, 0, 1, 5);
    step(1, "b_use_go",    enc_add(6, 5, 2),  1, 0, 0, 0, 0, 0, 0);
    check_cnt(1, "b_cnt_adj", 2);

    step(1, "b_lw_d2",     enc_lw(5, 1),      1, 0, 0, 0, 0, 0, 0);
    step(1, "b_indep",     enc_addi(9, 1),    1, 0, 0, 0, 0, 0, 0);
    step(1, "b_d2_stall",  enc_add(6, 5, 2),  1, 0, 0, 1, 0, 1, 5);
    step(1, "b_d2_go",     enc_add(6, 5, 2),  1, 0, 0, 0, 0, 0, 0);
    check_cnt(1, "b_cnt_d2", 3);

    step(1, "b_lw_d3",     enc_lw(5, 1),      1, 0, 0, 0, 0, 0, 0);
    step(1, "b_indep1",    enc_addi(9, 1),    1, 0, 0, 0, 0, 0, 0);
    step(1, "b_indep2",    enc_addi(10, 1),   1, 0, 0, 0, 0, 0, 0);
    step(1, "b_d3_nostall", enc_add(6, 5, 2), 1, 0, 0, 0, 0, 0, 0);

    step(1, "b_lw5",       enc_lw(5, 1),      1, 0, 0, 0, 0, 0, 0);
    step(1, "b_lw6",       enc_lw(6, 1),      1, 0, 0, 0, 0, 0, 0);
    step(1, "b_both_c1",   enc_add(7, 6, 5),  1, 0, 0, 1, 0, 1, 6);
    step(1, "b_both_c2",   enc_add(7, 6, 5),  1, 0, 0, 1, 0, 1, 6);
    step(1, "b_both_go",   enc_add(7, 6, 5),  1, 0, 0, 0, 0, 0, 0);
    check_cnt(1, "b_cnt_both", 5);

    step(1, "b_lw_base",   enc_lw(5, 1),      1, 0, 0, 0, 0, 0, 0);
    step(1, "b_ll_c1",     enc_lw(7, 5),      1, 0, 0, 1, 0, 1, 5);
    step(1, "b_ll_c2",     enc_lw(7, 5),      1, 0, 0, 1, 0, 1, 5);
    step(1, "b_ll_go",     enc_lw(7, 5),      1, 0, 0, 0, 0, 0, 0);
    step(1, "b_ll_use_c1", enc_add(8, 7, 0),  1, 0, 0, 1, 0, 1, 7);
    step(1, "b_ll_use_c2", enc_add(8, 7, 0),  1, 0, 0, 1, 0, 1, 7);
    step(1, "b_ll_use_go", enc_add(8, 7, 0),  1, 0, 0, 0, 0, 0, 0);
    check_cnt(1, "b_cnt_ll", 9);

    step(1, "b_lw_fl",     enc_lw(5, 1),      1, 0, 0, 0, 0, 0, 0);
    step(1, "b_beq_flush", enc_beq(5, 5),     1, 1, 0, 0, 0, 0, 0);
    step(1, "b_after_fl",  enc_add(6, 5, 2),  1, 0, 0, 1, 0, 1, 5);
    step(1, "b_after_go",  enc_add(6, 5, 2),  1, 0, 0, 0, 0, 0, 0);
    check_cnt(1, "b_cnt_flush", 10);
    step(1, "b_idle",      32'd0,             0, 0, 0, 0, 0, 0, 0);

    // ---------------- reset in the middle of a stall ----------------
    step(0, "a_lw_rst",    enc_lw(5, 1),      1, 0, 0, 0, 0, 0, 0);
    step(0, "a_stall_rst", enc_add(6, 5, 2),  1, 0, 0, 1, 0, 1, 5);
    #1 rst = 1'b0;
    #1;
    check("a_async_rst_status", status(1'b0), 32'd0);
    check("a_async_rst_cnt", 32'(bus_a.stall_cycles), 32'd0);
    check("b_async_rst_cnt", 32'(bus_b.stall_cycles), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    step(0, "a_post_rst",  enc_add(6, 5, 2),  1, 0, 0, 0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
